// File: rtl/mem_ctrl_if.sv
// Bundle of the IF fetch port, MEM load/store port and byte-wide RAM/IO pins around mem_ctrl.
// slave = mem_ctrl side, master = pipeline/RAM side.
interface mem_ctrl_if #(
  parameter int ADDR_W = 32
);
  logic              flush_i;
  logic              if_req_i;
  logic [ADDR_W-1:0] if_addr_i;
  logic              if_done_o;
  logic [31:0]       if_inst_o;
  logic              mem_req_i;
  logic              mem_we_i;
  logic [1:0]        mem_size_i;
  logic [ADDR_W-1:0] mem_addr_i;
  logic [31:0]       mem_wdata_i;
  logic              mem_done_o;
  logic [31:0]       mem_rdata_o;
  logic [7:0]        ram_din_i;
  logic [7:0]        ram_dout_o;
  logic [ADDR_W-1:0] ram_a_o;
  logic              ram_wr_o;
  logic              io_buffer_full_i;

  modport slave (
    input  flush_i, if_req_i, if_addr_i, mem_req_i, mem_we_i, mem_size_i, mem_addr_i,
           mem_wdata_i, ram_din_i, io_buffer_full_i,
    output if_done_o, if_inst_o, mem_done_o, mem_rdata_o, ram_dout_o, ram_a_o, ram_wr_o
  );

  modport master (
    output flush_i, if_req_i, if_addr_i, mem_req_i, mem_we_i, mem_size_i, mem_addr_i,
           mem_wdata_i, ram_din_i, io_buffer_full_i,
    input  if_done_o, if_inst_o, mem_done_o, mem_rdata_o, ram_dout_o, ram_a_o, ram_wr_o
  );
endinterface

// File: rtl/mem_ctrl.sv
// Byte-serial RAM arbiter for IF and MEM: N-byte read done N+2 cycles after accept, write N+1.
// rdy low freezes everything; IO-region writes stall while io_buffer_full_i is high.
module mem_ctrl #(
  parameter int ADDR_W = 32,
  parameter int IO_HI  = 17
) (
  input logic       clk,
  input logic       rst,
  input logic       rdy,
  mem_ctrl_if.slave bus
);
  typedef enum logic [2:0] {IDLE, IF_RD, MEM_RD, MEM_WR, DONE} state_e;

  state_e            state_q, state_d;
  logic [2:0]        cnt_q, cnt_d, n_q, n_d;
  logic [31:0]       buf_q, buf_d, wdata_q, wdata_d;
  logic [31:0]       if_inst_q, if_inst_d, mem_rdata_q, mem_rdata_d;
  logic [ADDR_W-1:0] ram_a_q, ram_a_d;
  logic [7:0]        ram_dout_q, ram_dout_d;
  logic              ram_wr_q, ram_wr_d, if_done_q, if_done_d, mem_done_q, mem_done_d;
  logic              io_blk;
  logic [4:0]        shamt;
  logic [31:0]       rd_word;

  function automatic logic [2:0] nbytes(input logic [1:0] size);
    case (size)
      2'd0:    return 3'd1;
      2'd1:    return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

  assign io_blk = (ram_a_q[IO_HI:IO_HI-1] == 2'b11) && bus.io_buffer_full_i;

  // Bytes shift in from the top; short reads are right-aligned so upper bytes read as zero.
  always_comb begin
    shamt = 5'd0;
    case (n_q)
      3'd1:    shamt = 5'd24;
      3'd2:    shamt = 5'd16;
      default: shamt = 5'd0;
    endcase
    rd_word = {bus.ram_din_i, buf_q[31:8]} >> shamt;
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    n_d         = n_q;
    buf_d       = buf_q;
    wdata_d     = wdata_q;
    ram_a_d     = ram_a_q;
    ram_dout_d  = ram_dout_q;
    ram_wr_d    = ram_wr_q;
    if_inst_d   = if_inst_q;
    mem_rdata_d = mem_rdata_q;
    if_done_d   = 1'b0;
    mem_done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.mem_req_i) begin
          ram_a_d = bus.mem_addr_i;
          cnt_d   = 3'd0;
          n_d     = nbytes(bus.mem_size_i);
          if (bus.mem_we_i) begin
            state_d    = MEM_WR;
            ram_dout_d = bus.mem_wdata_i[7:0];
            wdata_d    = {8'h00, bus.mem_wdata_i[31:8]};
            ram_wr_d   = 1'b1;
          end else begin
            state_d = MEM_RD;
          end
        end else if (bus.if_req_i && !bus.flush_i) begin
          state_d = IF_RD;
          ram_a_d = bus.if_addr_i;
          cnt_d   = 3'd0;
          n_d     = 3'd4;
        end
      end
      IF_RD, MEM_RD: begin
        // A mispredict only kills the younger fetch; loads belong to an older instruction.
        if (state_q == IF_RD && bus.flush_i) begin
          state_d = IDLE;
        end else begin
          if (cnt_q != 3'd0) buf_d = {bus.ram_din_i, buf_q[31:8]};
          if (cnt_q == n_q) begin
            state_d = DONE;
            if (state_q == IF_RD) begin
              if_inst_d = rd_word;
              if_done_d = 1'b1;
            end else begin
              mem_rdata_d = rd_word;
              mem_done_d  = 1'b1;
            end
          end else begin
            cnt_d = cnt_q + 3'd1;
            if (cnt_q + 3'd1 < n_q) ram_a_d = ram_a_q + ADDR_W'(1);
          end
        end
      end
      MEM_WR: begin
        if (!io_blk) begin
          if (cnt_q == n_q - 3'd1) begin
            state_d    = DONE;
            ram_wr_d   = 1'b0;
            mem_done_d = 1'b1;
          end else begin
            cnt_d      = cnt_q + 3'd1;
            ram_a_d    = ram_a_q + ADDR_W'(1);
            ram_dout_d = wdata_q[7:0];
            wdata_d    = {8'h00, wdata_q[31:8]};
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= 3'd0;
      n_q         <= 3'd0;
      buf_q       <= '0;
      wdata_q     <= '0;
      ram_a_q     <= '0;
      ram_dout_q  <= '0;
      ram_wr_q    <= 1'b0;
      if_inst_q   <= '0;
      mem_rdata_q <= '0;
      if_done_q   <= 1'b0;
      mem_done_q  <= 1'b0;
    end else if (rdy) begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      n_q         <= n_d;
      buf_q       <= buf_d;
      wdata_q     <= wdata_d;
      ram_a_q     <= ram_a_d;
      ram_dout_q  <= ram_dout_d;
      ram_wr_q    <= ram_wr_d;
      if_inst_q   <= if_inst_d;
      mem_rdata_q <= mem_rdata_d;
      if_done_q   <= if_done_d;
      mem_done_q  <= mem_done_d;
    end
  end

  assign bus.if_done_o   = if_done_q & rdy & ~bus.flush_i;
  assign bus.mem_done_o  = mem_done_q & rdy;
  assign bus.if_inst_o   = if_inst_q;
  assign bus.mem_rdata_o = mem_rdata_q;
  assign bus.ram_a_o     = ram_a_q;
  assign bus.ram_dout_o  = ram_dout_q;
  assign bus.ram_wr_o    = ram_wr_q & rdy & ~io_blk;
endmodule
